// File: rtl/trng_health_packer.sv
// Continuous RCT/APT health testing of the trng bit stream with start-up/run/alarm
// gating, and LSB-first packing of healthy bits into valid/ready output words.
module trng_health_packer #(
   parameter int unsigned WORD_W       = 32,
   parameter int unsigned RCT_CUTOFF   = 21,
   parameter int unsigned APT_WINDOW   = 1024,
   parameter int unsigned APT_CUTOFF   = 589,
   parameter int unsigned STARTUP_BITS = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_bit,
   input  logic              clear_alarm,
   output logic [WORD_W-1:0] out_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              rct_fail,
   output logic              apt_fail,
   output logic              alarm,
   output logic              overflow,
   output logic [1:0]        state
);

   localparam int unsigned RUN_W = $clog2(RCT_CUTOFF + 1);
   localparam int unsigned APT_W = $clog2(APT_WINDOW + 1);
   localparam int unsigned SU_W  = $clog2(STARTUP_BITS + 1);
   localparam int unsigned IDX_W = $clog2(WORD_W);

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_RUN     = 2'd1,
      ST_ALARM   = 2'd2
   } state_t;

   state_t cur_st, nxt_st;

   logic              last_valid, last_bit;
   logic [RUN_W-1:0]  run_cnt;
   logic              apt_ref;
   logic [APT_W-1:0]  apt_cnt, apt_match;
   logic [SU_W-1:0]   su_cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [WORD_W-1:0] pack_buf;

   logic              accept, rct_same, rct_hit, apt_new, apt_hit, fail;
   logic              su_done, clr, pack_en, word_done;
   logic [WORD_W-1:0] full_word;

   always_comb begin
      accept    = in_valid && (cur_st != ST_ALARM);
      rct_same  = last_valid && (in_bit == last_bit);
      rct_hit   = accept && rct_same && (run_cnt == RUN_W'(RCT_CUTOFF - 1));
      // an empty counter or a finished window both mean this bit becomes the reference
      apt_new   = (apt_cnt == '0) || (apt_cnt == APT_W'(APT_WINDOW));
      apt_hit   = accept && !apt_new && (in_bit == apt_ref) &&
                  (apt_match == APT_W'(APT_CUTOFF - 1));
      fail      = rct_hit || apt_hit;
      su_done   = accept && (cur_st == ST_STARTUP) && (su_cnt == SU_W'(STARTUP_BITS - 1));
      clr       = (cur_st == ST_ALARM) && clear_alarm;
      pack_en   = accept && (cur_st == ST_RUN) && !fail;
      word_done = pack_en && (bit_idx == IDX_W'(WORD_W - 1));
      full_word = pack_buf;
      full_word[bit_idx] = in_bit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_st <= ST_STARTUP;
      else       cur_st <= nxt_st;
   end

   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         ST_STARTUP: if (fail) nxt_st = ST_ALARM;
                     else if (su_done) nxt_st = ST_RUN;
         ST_RUN:     if (fail) nxt_st = ST_ALARM;
         ST_ALARM:   if (clear_alarm) nxt_st = ST_STARTUP;
         default:    nxt_st = ST_STARTUP;
      endcase
   end

   always_comb begin
      alarm = (cur_st == ST_ALARM);
      state = cur_st;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_valid <= 1'b0;
         last_bit   <= 1'b0;
         run_cnt    <= '0;
         apt_ref    <= 1'b0;
         apt_cnt    <= '0;
         apt_match  <= '0;
         su_cnt     <= '0;
         bit_idx    <= '0;
         pack_buf   <= '0;
         out_word   <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
         rct_fail   <= 1'b0;
         apt_fail   <= 1'b0;
      end else begin
         rct_fail <= rct_hit;
         apt_fail <= apt_hit;
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (clr) begin
            last_valid <= 1'b0;
            run_cnt    <= '0;
            apt_cnt    <= '0;
            apt_match  <= '0;
            su_cnt     <= '0;
            bit_idx    <= '0;
            pack_buf   <= '0;
            overflow   <= 1'b0;
         end else if (accept) begin
            if (rct_same) begin
               if (run_cnt != RUN_W'(RCT_CUTOFF)) run_cnt <= run_cnt + RUN_W'(1);
            end else begin
               run_cnt    <= RUN_W'(1);
               last_bit   <= in_bit;
               last_valid <= 1'b1;
            end
            if (apt_new) begin
               apt_ref   <= in_bit;
               apt_cnt   <= APT_W'(1);
               apt_match <= APT_W'(1);
            end else begin
               apt_cnt <= apt_cnt + APT_W'(1);
               if (in_bit == apt_ref) apt_match <= apt_match + APT_W'(1);
            end
            if (cur_st == ST_STARTUP) su_cnt <= su_cnt + SU_W'(1);
            // the failing bit is never packed, and any pending word is now suspect
            if (fail) begin
               bit_idx   <= '0;
               out_valid <= 1'b0;
            end else if (pack_en) begin
               pack_buf <= full_word;
               if (word_done) begin
                  bit_idx <= '0;
                  if (!out_valid || out_ready) begin
                     out_word  <= full_word;
                     out_valid <= 1'b1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end else begin
                  bit_idx <= bit_idx + IDX_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_trng_health_packer.sv
// Scoreboarded bench for trng_health_packer: startup gating, packing, RCT/APT alarms,
// overflow, clear_alarm recovery and asynchronous reset.
module tb_trng_health_packer;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_bit, clear_alarm, out_ready;
   logic [7:0] out_word;
   logic       out_valid, rct_fail, apt_fail, alarm, overflow;
   logic [1:0] state;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [7:0]  exp_q[$];

   trng_health_packer #(
      .WORD_W(8), .RCT_CUTOFF(4), .APT_WINDOW(16), .APT_CUTOFF(12), .STARTUP_BITS(16)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
      .clear_alarm(clear_alarm), .out_word(out_word), .out_valid(out_valid),
      .out_ready(out_ready), .rct_fail(rct_fail), .apt_fail(apt_fail),
      .alarm(alarm), .overflow(overflow), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // words leave the DUT on an edge with out_valid && out_ready; sample mid-cycle
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_word", {56'd0, out_word}, 64'hdead);
         else                   check("word", {56'd0, out_word}, {56'd0, exp_q.pop_front()});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b);
      in_valid = 1'b1;
      in_bit   = b;
      step();
      in_valid = 1'b0;
   endtask

   // bits[n-1] arrives first
   task automatic send_seq(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) send(bits[i]);
   endtask

   task automatic startup_run(input string tag);
      for (int i = 0; i < 16; i++) begin
         check({tag, "_startup_state"}, state, 0);
         send(1'(i & 1));
      end
      check({tag, "_run_state"}, state, 1);
      check({tag, "_run_no_valid"}, out_valid, 0);
   endtask

   task automatic pulse_clear();
      clear_alarm = 1'b1;
      step();
      clear_alarm = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_alarm = 1'b0; out_ready = 1'b1;
      step(); step();
      check("rst_state", state, 0);
      check("rst_valid", out_valid, 0);
      check("rst_word", out_word, 0);
      check("rst_rct", rct_fail, 0);
      check("rst_apt", apt_fail, 0);
      check("rst_alarm", alarm, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;
      step();

      startup_run("p1");

      exp_q.push_back(8'h4D);
      send_seq(16'b1011_0010, 8);
      check("p2_valid", out_valid, 1);
      check("p2_word", out_word, 8'h4D);
      step();
      check("p2_valid_clr", out_valid, 0);

      out_ready = 1'b0;
      exp_q.push_back(8'h55);
      send_seq(16'b1010_1010, 8);
      check("ovf_first_valid", out_valid, 1);
      check("ovf_pre", overflow, 0);
      send_seq(16'b0110_0110, 8);
      check("ovf_held_word", out_word, 8'h55);
      check("ovf_held_valid", out_valid, 1);
      check("ovf_set", overflow, 1);
      out_ready = 1'b1;
      step();
      check("ovf_drain", out_valid, 0);
      check("ovf_sticky", overflow, 1);

      out_ready = 1'b0;
      send_seq(16'b1001_1011, 8);
      check("rct_pending_valid", out_valid, 1);
      send_seq(16'b000, 3);
      check("rct_pre_state", state, 1);
      check("rct_pre_pulse", rct_fail, 0);
      send(1'b0);
      check("rct_pulse", rct_fail, 1);
      check("rct_apt_quiet", apt_fail, 0);
      check("rct_state", state, 2);
      check("rct_alarm", alarm, 1);
      check("rct_valid_drop", out_valid, 0);
      for (int i = 0; i < 3; i++) begin
         send(1'b0);
         check("alarm_ignore_state", state, 2);
         check("alarm_ignore_rct", rct_fail, 0);
      end

      out_ready = 1'b1;
      pulse_clear();
      check("clr_state", state, 0);
      check("clr_alarm", alarm, 0);
      check("clr_ovf", overflow, 0);
      startup_run("p5");
      exp_q.push_back(8'h4B);
      send_seq(16'b1101_0010, 8);
      check("p5_word", out_word, 8'h4B);
      step();
      exp_q.push_back(8'h55);
      send_seq(16'b1010_1010, 8);
      step();

      exp_q.push_back(8'h77);
      send_seq(16'b1110_1110_1110, 12);
      send_seq(16'b11, 2);
      check("apt_pre_state", state, 1);
      check("apt_pre_pulse", apt_fail, 0);
      send(1'b1);
      check("apt_pulse", apt_fail, 1);
      check("apt_rct_quiet", rct_fail, 0);
      check("apt_state", state, 2);
      step();
      check("apt_pulse_end", apt_fail, 0);

      pulse_clear();
      startup_run("p7");
      out_ready = 1'b0;
      send_seq(16'b1011_0100, 8);
      check("p7_word", out_word, 8'h2D);
      check("p7_valid", out_valid, 1);
      send(1'b1);
      reset = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_word", out_word, 0);
      check("arst_state", state, 0);
      check("arst_alarm", alarm, 0);
      step();
      reset = 1'b0;
      step();
      check("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trng_health_packer.md
Name: trng_health_packer

Overview:
- Sits directly downstream of the trng stage and consumes its serial (out_valid, out) bit stream.
- Runs continuous SP 800-90B style health tests: a repetition count test (RCT) and an adaptive proportion test (APT).
- Gates output through a start-up/run/alarm state machine.
- Packs healthy bits LSB-first into words presented on a valid/ready interface.

Parameters:
- WORD_W, 32, output word width (2..64).
- RCT_CUTOFF, 21, run length of identical bits that flags RCT failure (>=2).
- APT_WINDOW, 1024, APT window length in accepted bits.
- APT_CUTOFF, 589, matches to the window reference bit that flag APT failure (<=APT_WINDOW).
- STARTUP_BITS, 1024, bits tested but never output after reset or clear_alarm.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  bit strobe from trng out_valid.
- in_bit  in  1  random bit from trng out.
- clear_alarm  in  1  single-cycle pulse; leaves ALARM.
- out_word  out  WORD_W  packed word, bit 0 = oldest bit.
- out_valid  out  1  out_word holds an unconsumed word.
- out_ready  in  1  consumer accepts word.
- rct_fail  out  1  one-cycle pulse on RCT failure.
- apt_fail  out  1  one-cycle pulse on APT failure.
- alarm  out  1  high while in ALARM.
- overflow  out  1  sticky; a completed word was dropped because the output was full. Cleared by reset or clear_alarm.
- state  out  2  0=STARTUP, 1=RUN, 2=ALARM.

Behaviour:
- Reset:
  - All outputs are 0; state is STARTUP.
  - All counters and shift registers are 0.
  - The RCT last-bit register is marked invalid.
- Bit acceptance: a bit is accepted only on a clk edge where in_valid=1. Bits are ignored entirely in ALARM. There is no backpressure upstream.
- RCT:
  - The first bit after reset or clear sets last=in_bit and run=1.
  - For later bits: if in_bit equals last, run increments, saturating at RCT_CUTOFF. Otherwise run=1 and last=in_bit.
  - When run becomes equal to RCT_CUTOFF, rct_fail pulses in the next cycle (registered).
- APT:
  - The first bit of each window is the reference, with match=1 and cnt=1.
  - Each later bit increments cnt and, if it equals the reference, increments match.
  - When match becomes equal to APT_CUTOFF, apt_fail pulses (registered).
  - When cnt reaches APT_WINDOW, the next accepted bit starts a new window.
- State machine:
  - STARTUP→RUN after STARTUP_BITS accepted bits with no failure.
  - STARTUP or RUN → ALARM on any failure, in the same cycle rct_fail/apt_fail asserts.
  - ALARM→STARTUP on clear_alarm. The RCT, APT, startup and packer counters clear, and overflow clears.
  - If clear_alarm coincides with a failure detected in RUN/STARTUP, the failure wins: state goes to ALARM.
  - If clear_alarm arrives outside ALARM, it is ignored.
- Packer:
  - Active only in RUN.
  - An accepted bit is written into position bit_idx; bit_idx increments.
  - On the WORD_W-th bit, the word is complete:
    - If out_valid=0, or out_valid&&out_ready in that cycle, the word loads into out_word and out_valid=1 on the next edge (latency 1 cycle after the last bit).
    - Otherwise the word is dropped and overflow sets.
  - bit_idx always returns to 0 after a complete word.
  - The bit that triggers a failure is not packed.
- Entering ALARM:
  - Discards the partial word (bit_idx=0).
  - Clears out_valid. An undelivered word is invalidated because its bits precede a failure window.
- Output handshake:
  - out_word is stable while out_valid=1 and out_ready=0.
  - The transfer occurs on an edge with out_valid&&out_ready.
- Reset mid-operation forces the reset values immediately (asynchronous), regardless of state.

Test Plan (WORD_W=8, RCT_CUTOFF=4, APT_WINDOW=16, APT_CUTOFF=12, STARTUP_BITS=16):
- Reset, then 16 alternating bits (0101…) → state 0 for all 16; state=1 on the edge after the 16th; out_valid stays 0.
- In RUN, send 1,0,1,1,0,0,1,0 with out_ready=1 → out_word=8'h4D (bit0 first), out_valid=1 one cycle after the 8th bit, cleared after the handshake.
- In RUN, send 0,0,0,0 → rct_fail pulses once after the 4th zero; state=2, alarm=1, out_valid=0, partial word discarded; further in_valid ignored.
- Window of 16 bits: reference 1 followed by 1s interleaved with 0s avoiding runs of 4 (e.g. 1,1,1,0 repeated) → apt_fail when match hits 12; state=2.
- out_ready=0 during two complete words → first word held unchanged; second dropped; overflow=1; after out_ready=1, first word transfers.
- In ALARM, pulse clear_alarm → state=0, overflow=0, counters clear; 16 alternating bits return to RUN. Assert reset mid-word → all outputs 0 immediately.
